// File: rtl/pipe_pkg.sv
// Shared types and per-stage bundle widths for the elastic pipeline-stage register.
// Instantiating stages pick their CTRL_W/DATA_W from the localparams below.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } pipe_state_e;

   typedef logic [1:0] occ_t;

   localparam int IF_ID_CTRL_W  = 4;
   localparam int IF_ID_DATA_W  = 64;
   localparam int ID_EX_CTRL_W  = 8;
   localparam int ID_EX_DATA_W  = 128;
   localparam int EX_MEM_CTRL_W = 6;
   localparam int EX_MEM_DATA_W = 104;
   localparam int MEM_WB_CTRL_W = 3;
   localparam int MEM_WB_DATA_W = 69;

   function automatic occ_t state_occ(input pipe_state_e s);
      case (s)
         BUSY:    return 2'd1;
         FULL:    return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One-entry holding register (valid + ctrl + data) with load and clear.
// Clear beats load so a flush discards a same-cycle load; clear keeps the data bits.
module pipe_skid_slot
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         ctrl_d  = in_ctrl;
         data_d  = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
      end
   end

   // A dead entry must never leak stale control bits downstream.
   assign valid = valid_q;
   assign ctrl  = valid_q ? ctrl_q : '0;
   assign data  = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: valid/ready handshake, stall, flush, bubbles.
// SKID=1 adds a second slot so in_ready comes straight from a flop.
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 128,
   parameter bit SKID   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   pipe_state_e       state_q, state_d;
   logic              accept, retire;
   logic              main_load, main_clear, main_sel_skid;
   logic              skid_load, skid_clear;
   logic [CTRL_W-1:0] main_ctrl_in;
   logic [DATA_W-1:0] main_data_in;
   occ_t              occ;

   assign accept = in_valid & in_ready;
   assign retire = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (reset) state_q <= EMPTY;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (accept) state_d = BUSY;
         BUSY: begin
            if (accept && !retire)      state_d = SKID ? FULL : BUSY;
            else if (!accept && retire) state_d = EMPTY;
         end
         FULL:    if (retire) state_d = BUSY;
         default: state_d = EMPTY;
      endcase
      if (flush) state_d = EMPTY;
   end

   always_comb begin
      main_load     = 1'b0;
      main_clear    = 1'b0;
      main_sel_skid = 1'b0;
      skid_load     = 1'b0;
      skid_clear    = 1'b0;
      case (state_q)
         EMPTY: main_load = accept;
         BUSY: begin
            if (accept && retire) main_load  = 1'b1;
            else if (accept)      skid_load  = 1'b1;
            else if (retire)      main_clear = 1'b1;
         end
         FULL: begin
            if (retire) begin
               main_load     = 1'b1;
               main_sel_skid = 1'b1;
               skid_clear    = 1'b1;
            end
         end
         default: ;
      endcase
      // Flush overrides every load, including an input accepted this cycle.
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end
   end

   pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk     (clk),
      .reset   (reset),
      .load    (main_load),
      .clear   (main_clear),
      .in_ctrl (main_ctrl_in),
      .in_data (main_data_in),
      .valid   (out_valid),
      .ctrl    (out_ctrl),
      .data    (out_data)
   );

   generate
      if (SKID) begin : g_skid
         logic              skid_valid;
         logic [CTRL_W-1:0] skid_ctrl;
         logic [DATA_W-1:0] skid_data;
         logic              in_ready_q, in_ready_d;

         pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
            .clk     (clk),
            .reset   (reset),
            .load    (skid_load),
            .clear   (skid_clear),
            .in_ctrl (in_ctrl),
            .in_data (in_data),
            .valid   (skid_valid),
            .ctrl    (skid_ctrl),
            .data    (skid_data)
         );

         assign main_ctrl_in = (main_sel_skid && skid_valid) ? skid_ctrl : in_ctrl;
         assign main_data_in = (main_sel_skid && skid_valid) ? skid_data : in_data;

         // Ready looks one state ahead so it can be a flop with no path from out_ready.
         assign in_ready_d = (state_d != FULL);

         always_ff @(posedge clk) begin
            if (reset) in_ready_q <= 1'b1;
            else       in_ready_q <= in_ready_d;
         end

         assign in_ready = in_ready_q;
      end else begin : g_single
         logic unused_skid_ctl;
         assign unused_skid_ctl = ^{main_sel_skid, skid_load, skid_clear};
         assign main_ctrl_in    = in_ctrl;
         assign main_data_in    = in_data;
         assign in_ready        = ~out_valid | out_ready;
      end
   endgenerate

   assign occ       = state_occ(state_q);
   assign occupancy = occ;

   a_bubble_ctrl_zero: assert property (@(posedge clk) disable iff (reset)
      !out_valid |-> (out_ctrl == '0));
   a_valid_tracks_state: assert property (@(posedge clk) disable iff (reset)
      out_valid == (state_q != EMPTY));
   a_no_full_single: assert property (@(posedge clk) disable iff (reset)
      !SKID |-> (state_q != FULL));

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: SKID=1 and SKID=0 instances checked against a FIFO model
// every cycle, plus directed vectors with literal expectations.
module tb_pipe_stage_elastic;

   localparam int CW = 8;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // index 1 drives the SKID=1 instance, index 0 the SKID=0 instance
   logic [1:0]    rst, fl, v, ordy;
   logic [CW-1:0] c [2];
   logic [DW-1:0] d [2];

   logic          rdy0, rdy1, ov0, ov1;
   logic [CW-1:0] oc0, oc1;
   logic [DW-1:0] od0, od1;
   logic [1:0]    occ0, occ1;

   int checks   = 0;
   int failures = 0;

   pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) u_dut1 (
      .clk(clk), .reset(rst[1]), .flush(fl[1]), .in_valid(v[1]), .in_ready(rdy1),
      .in_ctrl(c[1]), .in_data(d[1]), .out_valid(ov1), .out_ready(ordy[1]),
      .out_ctrl(oc1), .out_data(od1), .occupancy(occ1));

   pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) u_dut0 (
      .clk(clk), .reset(rst[0]), .flush(fl[0]), .in_valid(v[0]), .in_ready(rdy0),
      .in_ctrl(c[0]), .in_data(d[0]), .out_valid(ov0), .out_ready(ordy[0]),
      .out_ctrl(oc0), .out_data(od0), .occupancy(occ0));

   // Model: a FIFO of capacity 2 (SKID=1) or 1 with pass-through ready (SKID=0).
   int            m_cnt  [2];
   logic [CW-1:0] m_c    [2][2];
   logic [DW-1:0] m_d    [2][2];
   logic [DW-1:0] m_last [2];
   bit            m_live [2];

   function automatic bit exp_rdy(input int k);
      if (k == 1) return m_cnt[1] < 2;
      return (m_cnt[0] == 0) || ordy[0];
   endfunction

   always @(posedge clk) begin
      bit acc, ret;
      for (int k = 0; k < 2; k++) begin
         if (rst[k]) begin
            m_cnt[k]  = 0;
            m_last[k] = '0;
            m_live[k] = 1'b1;
         end else if (m_live[k]) begin
            acc = v[k] && exp_rdy(k);
            ret = (m_cnt[k] > 0) && ordy[k];
            if (fl[k]) begin
               m_cnt[k] = 0;
            end else begin
               if (ret) begin
                  m_c[k][0] = m_c[k][1];
                  m_d[k][0] = m_d[k][1];
                  m_cnt[k]--;
               end
               if (acc) begin
                  m_c[k][m_cnt[k]] = c[k];
                  m_d[k][m_cnt[k]] = d[k];
                  m_cnt[k]++;
               end
            end
            if (m_cnt[k] > 0) m_last[k] = m_d[k][0];
         end
      end
   end

   task automatic cmp(input int k, input logic rdy_a, input logic ov_a,
                      input logic [CW-1:0] oc_a, input logic [DW-1:0] od_a,
                      input logic [1:0] occ_a);
      logic          er, ev;
      logic [CW-1:0] ec;
      logic [DW-1:0] ed;
      logic [1:0]    eo;
      er = exp_rdy(k);
      ev = (m_cnt[k] > 0);
      ec = ev ? m_c[k][0] : '0;
      ed = ev ? m_d[k][0] : m_last[k];
      eo = 2'(m_cnt[k]);
      checks++;
      if ({rdy_a, ov_a, oc_a, od_a, occ_a} !== {er, ev, ec, ed, eo}) begin
         failures++;
         $display("FAIL model_cmp skid%0d t=%0t got rdy=%b v=%b ctrl=%h data=%h occ=%0d want rdy=%b v=%b ctrl=%h data=%h occ=%0d",
                  k, $time, rdy_a, ov_a, oc_a, od_a, occ_a, er, ev, ec, ed, eo);
      end
   endtask

   always @(negedge clk) begin
      if (m_live[1]) cmp(1, rdy1, ov1, oc1, od1, occ1);
      if (m_live[0]) cmp(0, rdy0, ov0, oc0, od0, occ0);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   int seq   [2];
   bit rdy_s [2];

   initial begin
      rst  = 2'b11; fl = 2'b00; v = 2'b11; ordy = 2'b11;
      c[0] = 8'hFF; c[1] = 8'hFF; d[0] = 32'hDEAD; d[1] = 32'hDEAD;
      cyc(); cyc();
      chk("rst_out_valid", 32'(ov1), 32'd0);
      chk("rst_out_ctrl", 32'(oc1), 32'd0);
      chk("rst_out_data", od1, 32'd0);
      chk("rst_occ", 32'(occ1), 32'd0);
      chk("rst_in_ready", 32'(rdy1), 32'd1);
      chk("rst_in_ready_s0", 32'(rdy0), 32'd1);
      rst = 2'b00; v = 2'b00;
      cyc();
      chk("post_rst_in_ready", 32'(rdy1), 32'd1);
      chk("post_rst_out_valid", 32'(ov1), 32'd0);

      // back-to-back stream, no stall: each entry visible one cycle after accept
      for (int i = 1; i <= 10; i++) begin
         v = 2'b11;
         c[0] = 8'(i); c[1] = 8'(i); d[0] = 32'(i); d[1] = 32'(i);
         cyc();
         chk($sformatf("stream1_ctrl_%0d", i), 32'(oc1), 32'(i));
         chk($sformatf("stream1_occ_%0d", i), 32'(occ1), 32'd1);
         chk($sformatf("stream0_data_%0d", i), od0, 32'(i));
      end
      v = 2'b00;
      cyc();
      chk("stream_end_valid", 32'(ov1), 32'd0);
      chk("stream_end_ctrl", 32'(oc1), 32'd0);
      chk("stream_end_data_hold", od1, 32'd10);

      // stall with skid: A,B captured, C held upstream until drained
      ordy[1] = 1'b0; v[1] = 1'b1; c[1] = 8'hA1; d[1] = 32'h0000_00A1;
      cyc();
      chk("skid_a_ctrl", 32'(oc1), 32'hA1);
      chk("skid_a_rdy", 32'(rdy1), 32'd1);
      c[1] = 8'hB2; d[1] = 32'h0000_00B2;
      cyc();
      chk("skid_b_occ", 32'(occ1), 32'd2);
      chk("skid_b_rdy", 32'(rdy1), 32'd0);
      c[1] = 8'hC3; d[1] = 32'h0000_00C3;
      cyc();
      chk("skid_c_held_ctrl", 32'(oc1), 32'hA1);
      chk("skid_c_held_data", od1, 32'h0000_00A1);
      chk("skid_c_held_occ", 32'(occ1), 32'd2);
      ordy[1] = 1'b1;
      cyc();
      chk("drain_b_ctrl", 32'(oc1), 32'hB2);
      chk("drain_b_occ", 32'(occ1), 32'd1);
      chk("drain_b_rdy", 32'(rdy1), 32'd1);
      cyc();
      chk("drain_c_ctrl", 32'(oc1), 32'hC3);
      v[1] = 1'b0;
      cyc();
      chk("drain_done_valid", 32'(ov1), 32'd0);
      chk("drain_done_data", od1, 32'h0000_00C3);

      // SKID=0: combinational ready follows out_ready while holding
      v[0] = 1'b1; ordy[0] = 1'b0; c[0] = 8'h5A; d[0] = 32'h5A5A;
      cyc();
      chk("s0_load_ctrl", 32'(oc0), 32'h5A);
      chk("s0_stall_rdy", 32'(rdy0), 32'd0);
      c[0] = 8'h6B; d[0] = 32'h6B6B;
      cyc();
      chk("s0_stall_hold", 32'(oc0), 32'h5A);
      ordy[0] = 1'b1;
      #1;
      chk("s0_rdy_comb", 32'(rdy0), 32'd1);
      cyc();
      chk("s0_next_ctrl", 32'(oc0), 32'h6B);
      v[0] = 1'b0;
      cyc();
      chk("s0_empty", 32'(ov0), 32'd0);

      // flush while FULL with a pending input
      ordy[1] = 1'b0; v[1] = 1'b1; c[1] = 8'hD4; d[1] = 32'h0000_D4D4;
      cyc();
      c[1] = 8'hE5; d[1] = 32'h0000_E5E5;
      cyc();
      chk("full_occ", 32'(occ1), 32'd2);
      fl[1] = 1'b1; c[1] = 8'hF6; d[1] = 32'h0000_F6F6;
      cyc();
      chk("flush_valid", 32'(ov1), 32'd0);
      chk("flush_ctrl", 32'(oc1), 32'd0);
      chk("flush_occ", 32'(occ1), 32'd0);
      chk("flush_rdy", 32'(rdy1), 32'd1);
      chk("flush_data_kept", od1, 32'h0000_D4D4);
      fl[1] = 1'b0; v[1] = 1'b0; ordy[1] = 1'b1;
      cyc();
      chk("flush_no_ghost", 32'(ov1), 32'd0);
      // input accepted in the flush cycle is discarded
      v[1] = 1'b1; fl[1] = 1'b1; c[1] = 8'h77; d[1] = 32'h7777;
      cyc();
      chk("flush_accept_dropped", 32'(ov1), 32'd0);
      fl[1] = 1'b0; v[1] = 1'b0;
      cyc();
      chk("flush_accept_gone", 32'(ov1), 32'd0);

      // reset and flush together while BUSY: reset wins, data cleared
      v[1] = 1'b1; ordy[1] = 1'b0; c[1] = 8'h88; d[1] = 32'h8888;
      cyc();
      chk("busy_data", od1, 32'h8888);
      rst[1] = 1'b1; fl[1] = 1'b1; v[1] = 1'b0;
      cyc();
      chk("rstflush_data", od1, 32'd0);
      chk("rstflush_valid", 32'(ov1), 32'd0);
      chk("rstflush_occ", 32'(occ1), 32'd0);
      rst[1] = 1'b0; fl[1] = 1'b0;
      cyc();
      chk("rstflush_rdy", 32'(rdy1), 32'd1);

      // random valid/ready/flush on both instances; model compares every cycle
      seq[0] = 1000; seq[1] = 5000;
      rdy_s[0] = 1'b0; rdy_s[1] = 1'b0;
      v = 2'b00;
      for (int n = 0; n < 10000; n++) begin
         for (int k = 0; k < 2; k++) begin
            if (v[k] && rdy_s[k]) seq[k]++;
            v[k]    = ($urandom_range(3) != 0);
            ordy[k] = ($urandom_range(9) < 7);
            fl[k]   = ($urandom_range(31) == 0);
            c[k]    = 8'(seq[k]) ^ 8'h3C;
            d[k]    = 32'(seq[k]);
         end
         @(negedge clk);
         rdy_s[0] = rdy0;
         rdy_s[1] = rdy1;
         cyc();
      end
      v = 2'b00; fl = 2'b00;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
